// File: rtl/spio_hss_multiplexer_frame_sched.sv
// Round-robin frame scheduler: requests one packet from a store, presents it as a frame, advances seq on accept.
// Optional counters under SPIO_HSS_FRAME_SCHED_STATS_EN (frm_cnt, miss_cnt).
module spio_hss_multiplexer_frame_sched #(
  parameter int NUM_CH   = 4,
  parameter int CH_BITS  = 2,
  parameter int SEQ_BITS = 7,
  parameter int PKT_BITS = 72
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stop,
  input  logic [NUM_CH-1:0]          ch_avail,
  output logic [NUM_CH-1:0]          ch_rq,
  output logic [SEQ_BITS-1:0]        ch_seq,
  input  logic [NUM_CH-1:0]          ch_gt,
  input  logic [NUM_CH*PKT_BITS-1:0] ch_data,
  output logic [PKT_BITS-1:0]        frm_data,
  output logic [CH_BITS-1:0]         frm_ch,
  output logic [SEQ_BITS-1:0]        frm_seq,
  output logic                       frm_vld,
  input  logic                       frm_rdy,
`ifdef SPIO_HSS_FRAME_SCHED_STATS_EN
  output logic [15:0]                frm_cnt,
  output logic [15:0]                miss_cnt,
`endif
  output logic                       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  state_t                r_state;
  logic [CH_BITS-1:0]    r_last;
  logic [CH_BITS-1:0]    r_sel;
  logic [SEQ_BITS-1:0]   r_seq;
  logic [NUM_CH-1:0]     r_ch_rq;
  logic [PKT_BITS-1:0]   r_frm_data;
  logic [CH_BITS-1:0]    r_frm_ch;
  logic [SEQ_BITS-1:0]   r_frm_seq;
  logic                  r_frm_vld;
  logic                  r_busy;
  logic [CH_BITS-1:0]    w_sel;
  logic                  w_found;
  logic                  w_accept;
  logic                  w_miss;

  // Round-robin pick: first available channel after the last served one, wrapping.
  always_comb begin
    logic [CH_BITS-1:0] idx;
    w_sel   = '0;
    w_found = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_BITS'((int'(r_last) + k) % NUM_CH);
      if (!w_found && ch_avail[idx]) begin
        w_sel   = idx;
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_accept = (r_state == ST_SEND) && frm_rdy;
  assign w_miss   = (r_state == ST_WAIT) && !ch_gt[r_sel];

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last     <= CH_BITS'(NUM_CH - 1);
      r_sel      <= '0;
      r_seq      <= '0;
      r_ch_rq    <= '0;
      r_frm_data <= '0;
      r_frm_ch   <= '0;
      r_frm_seq  <= '0;
      r_frm_vld  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!stop && w_found) begin
            r_sel   <= w_sel;
            r_ch_rq <= NUM_CH'(1) << w_sel;
            r_busy  <= 1'b1;
            r_state <= ST_REQ;
          end else begin
            r_ch_rq <= '0;
          end
        end
        ST_REQ: begin
          r_ch_rq <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ch_gt[r_sel]) begin
            r_frm_data <= ch_data[int'(r_sel)*PKT_BITS +: PKT_BITS];
            r_frm_ch   <= r_sel;
            r_frm_seq  <= r_seq;
            r_frm_vld  <= 1'b1;
            r_state    <= ST_SEND;
          end else begin
            // A miss still moves the pointer so a flaky store cannot hog arbitration.
            r_last  <= r_sel;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (frm_rdy) begin
            r_frm_vld <= 1'b0;
            r_seq     <= r_seq + SEQ_BITS'(1);
            r_last    <= r_sel;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_frm_vld <= 1'b1;
          end
        end
        default: begin
          r_ch_rq   <= '0;
          r_frm_vld <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ch_rq    = r_ch_rq;
  assign ch_seq   = r_seq;
  assign frm_data = r_frm_data;
  assign frm_ch   = r_frm_ch;
  assign frm_seq  = r_frm_seq;
  assign frm_vld  = r_frm_vld;
  assign busy     = r_busy;

`ifdef SPIO_HSS_FRAME_SCHED_STATS_EN
  logic [15:0] r_frm_cnt;
  logic [15:0] r_miss_cnt;

  // Saturating event counters, updated on the same edge as the event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frm_cnt  <= 16'd0;
      r_miss_cnt <= 16'd0;
    end else begin
      if (w_accept && (r_frm_cnt != 16'hFFFF)) begin
        r_frm_cnt <= r_frm_cnt + 16'd1;
      end else begin
        r_frm_cnt <= r_frm_cnt;
      end
      if (w_miss && (r_miss_cnt != 16'hFFFF)) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end else begin
        r_miss_cnt <= r_miss_cnt;
      end
    end
  end

  assign frm_cnt  = r_frm_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_sched.sv
// Directed bench for spio_hss_multiplexer_frame_sched; inputs change and outputs are checked on the falling edge.
module tb_spio_hss_multiplexer_frame_sched;

  localparam int NUM_CH   = 4;
  localparam int CH_BITS  = 2;
  localparam int SEQ_BITS = 7;
  localparam int PKT_BITS = 72;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       stop;
  logic [NUM_CH-1:0]          ch_avail;
  logic [NUM_CH-1:0]          ch_rq;
  logic [SEQ_BITS-1:0]        ch_seq;
  logic [NUM_CH-1:0]          ch_gt;
  logic [NUM_CH*PKT_BITS-1:0] ch_data;
  logic [PKT_BITS-1:0]        frm_data;
  logic [CH_BITS-1:0]         frm_ch;
  logic [SEQ_BITS-1:0]        frm_seq;
  logic                       frm_vld;
  logic                       frm_rdy;
  logic                       busy;
`ifdef SPIO_HSS_FRAME_SCHED_STATS_EN
  logic [15:0]                frm_cnt;
  logic [15:0]                miss_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spio_hss_multiplexer_frame_sched #(
    .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .SEQ_BITS(SEQ_BITS), .PKT_BITS(PKT_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stop(stop), .ch_avail(ch_avail), .ch_rq(ch_rq),
    .ch_seq(ch_seq), .ch_gt(ch_gt), .ch_data(ch_data), .frm_data(frm_data),
    .frm_ch(frm_ch), .frm_seq(frm_seq), .frm_vld(frm_vld), .frm_rdy(frm_rdy),
`ifdef SPIO_HSS_FRAME_SCHED_STATS_EN
    .frm_cnt(frm_cnt), .miss_cnt(miss_cnt),
`endif
    .busy(busy)
  );

  function automatic logic [PKT_BITS-1:0] pat(input int i);
    pat = {8'hC0 + 8'(i), 32'h1234_5678, 32'(i) * 32'h0101_0101 + 32'h0BAD_F00D};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stop = 1'b0; ch_avail = '0; ch_gt = '0; frm_rdy = 1'b0;
    for (int i = 0; i < NUM_CH; i++) ch_data[i*PKT_BITS +: PKT_BITS] = pat(i);
    tick(3);
    rst_n = 1'b1;

    // reset state
    chk("rst_vld", frm_vld, 0);  chk("rst_rq", ch_rq, 0);     chk("rst_busy", busy, 0);
    chk("rst_seq", ch_seq, 0);   chk("rst_data", frm_data, 0);
    chk("rst_ch", frm_ch, 0);    chk("rst_fseq", frm_seq, 0);
`ifdef SPIO_HSS_FRAME_SCHED_STATS_EN
    chk("rst_fcnt", frm_cnt, 0); chk("rst_mcnt", miss_cnt, 0);
`endif

    // single channel 2
    ch_avail = 4'b0100; ch_gt = 4'b0100;
    tick(1); chk("s_rq", ch_rq, 4'b0100); chk("s_busy", busy, 1);
    tick(1); chk("s_rq_pulse", ch_rq, 4'b0000); chk("s_vld_early", frm_vld, 0);
    tick(1); chk("s_vld", frm_vld, 1); chk("s_ch", frm_ch, 2); chk("s_fseq", frm_seq, 0);
    chk("s_data", frm_data, pat(2));
    frm_rdy = 1'b1;
    tick(1); chk("s_vld_off", frm_vld, 0); chk("s_seq1", ch_seq, 1); chk("s_idle", busy, 0);
    tick(3); chk("s2_vld", frm_vld, 1); chk("s2_ch", frm_ch, 2); chk("s2_fseq", frm_seq, 1);
    tick(1); ch_avail = '0;

    // round robin from reset
    do_reset();
    ch_avail = 4'b1111; ch_gt = 4'b1111; frm_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1); chk("rr_rq", ch_rq, 4'b0001 << (k % 4));
      tick(2); chk("rr_vld", frm_vld, 1); chk("rr_ch", frm_ch, k % 4);
      chk("rr_fseq", frm_seq, k); chk("rr_data", frm_data, pat(k % 4));
      tick(1); chk("rr_idle", frm_vld, 0);
    end
    ch_avail = '0;

    // miss on channel 0, channel 1 then served with seq 0
    do_reset();
    ch_avail = 4'b0011; ch_gt = 4'b0010; frm_rdy = 1'b1;
    tick(1); chk("m_rq0", ch_rq, 4'b0001);
    tick(2); chk("m_idle", busy, 0); chk("m_noseq", ch_seq, 0);
`ifdef SPIO_HSS_FRAME_SCHED_STATS_EN
    chk("m_mcnt", miss_cnt, 1);
`endif
    tick(1); chk("m_rq1", ch_rq, 4'b0010);
    tick(2); chk("m_vld", frm_vld, 1); chk("m_ch", frm_ch, 1); chk("m_fseq", frm_seq, 0);
    tick(1); ch_avail = '0;
`ifdef SPIO_HSS_FRAME_SCHED_STATS_EN
    chk("m_fcnt", frm_cnt, 1);
`endif

    // backpressure with stop during SEND
    frm_rdy = 1'b0; ch_avail = 4'b0001; ch_gt = 4'b0001;
    tick(3); chk("b_vld", frm_vld, 1); chk("b_ch", frm_ch, 0);
    stop = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1); chk("b_hold_vld", frm_vld, 1); chk("b_hold_seq", frm_seq, 1);
      chk("b_hold_data", frm_data, pat(0));
    end
    frm_rdy = 1'b1;
    tick(1); chk("b_acc", frm_vld, 0); chk("b_seq2", ch_seq, 2);
    for (int k = 0; k < 5; k++) begin
      tick(1); chk("b_stop_rq", ch_rq, 0); chk("b_stop_busy", busy, 0);
    end
    stop = 1'b0; ch_avail = '0;

    // sequence wrap over 130 frames
    do_reset();
    ch_avail = 4'b1111; ch_gt = 4'b1111; frm_rdy = 1'b1;
    for (int k = 0; k < 130; k++) begin
      tick(3); chk("w_fseq", frm_seq, k % 128); chk("w_ch", frm_ch, k % 4);
      tick(1);
    end
    ch_avail = '0;
    chk("w_seq", ch_seq, 2);
`ifdef SPIO_HSS_FRAME_SCHED_STATS_EN
    chk("w_fcnt", frm_cnt, 130); chk("w_mcnt", miss_cnt, 0);
`endif

    // reset in the middle of SEND
    ch_avail = 4'b1111; frm_rdy = 1'b0;
    tick(3); chk("r_vld", frm_vld, 1); chk("r_ch", frm_ch, 2); chk("r_fseq", frm_seq, 2);
    rst_n = 1'b0;
    tick(1); chk("r_drop", frm_vld, 0); chk("r_busy", busy, 0); chk("r_seq0", ch_seq, 0);
`ifdef SPIO_HSS_FRAME_SCHED_STATS_EN
    chk("r_fcnt", frm_cnt, 0);
`endif
    rst_n = 1'b1; frm_rdy = 1'b1;
    tick(1); chk("r_rq", ch_rq, 4'b0001);
    tick(2); chk("r2_vld", frm_vld, 1); chk("r2_ch", frm_ch, 0); chk("r2_fseq", frm_seq, 0);
    tick(1); ch_avail = '0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
